// File: rtl/wb_sram_slave_pkg.sv
// Shared state codes and bus constants for the wishbone SRAM responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wb_sram_slave_pkg;

    typedef enum logic [2:0] {
        WB_SRAM_IDLE   = 3'd0,
        WB_SRAM_SETUP  = 3'd1,
        WB_SRAM_ACCESS = 3'd2,
        WB_SRAM_ACK    = 3'd3,
        WB_SRAM_TURN   = 3'd4
    } wb_sram_state_t;

    localparam int SRAM_DEV_IDX = 0;
    localparam int REG_BUS_W    = 32;

    // A zero-length strobe cannot meet SRAM timing, so it is stretched to one cycle.
    function automatic int eff_wait(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_sram_slave_sram_io_pad.sv
// SRAM data-bus pad: tri-state write driver plus read-data capture register.
// Latency: capture visible one cycle after sample; drive is combinational.
// Backpressure: none; fully controlled by the owning FSM.
module sram_io_pad
    import wb_sram_slave_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_BUS_W-1:0] dout,
    input  logic                 drive,
    input  logic                 sample,
    output logic [REG_BUS_W-1:0] din,
    inout  wire  [REG_BUS_W-1:0] pad
);

    assign pad = drive ? dout : {REG_BUS_W{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din <= '0;
        end else if (sample) begin
            din <= pad;
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone responder for 32-bit async SRAM; optional range check under WB_SRAM_RANGE_CHK_EN.
// Latency: request in IDLE at cycle 0 -> ack at 2+WAIT_CYCLES; next request at 4+WAIT_CYCLES.
// Backpressure: none; master holds the request until the single-cycle ack.
module wb_sram_slave
    import wb_sram_slave_pkg::*;
#(
    parameter int DEV_IDX     = SRAM_DEV_IDX,
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wishbone_addr_i,
    input  logic [31:0]       wishbone_data_i,
    input  logic              wishbone_we_i,
    input  logic [15:0]       wishbone_select_i,
    output logic [31:0]       wishbone_data_o,
    output logic              wishbone_ack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [31:0]       sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o,
    output logic              err_o
);

    localparam int WAIT_EFF = eff_wait(WAIT_CYCLES);
    localparam int CNT_W    = (WAIT_EFF < 2) ? 1 : $clog2(WAIT_EFF);

    wb_sram_state_t       state, state_nxt;
    logic [ADDR_W-1:0]    addr_q;
    logic [31:0]          wdata_q;
    logic                 we_q;
    logic                 skip_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [31:0]          rdata;
    logic                 request;
    logic                 range_bad;
    logic                 drive;
    logic                 sample;
    logic                 sel_addr_unused;

    assign request         = wishbone_select_i[DEV_IDX];
    assign sel_addr_unused = ^{wishbone_select_i, wishbone_addr_i};
    assign sram_addr_o     = addr_q;
    assign sram_be_n_o     = 4'b0000;

`ifdef WB_SRAM_RANGE_CHK_EN
    localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

    logic err_q;

    assign range_bad = |(wishbone_addr_i & HI_MASK);
    assign err_o     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state == WB_SRAM_IDLE && request && range_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign range_bad = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WB_SRAM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        sram_ce_n_o     = 1'b1;
        sram_oe_n_o     = 1'b1;
        sram_we_n_o     = 1'b1;
        drive           = 1'b0;
        sample          = 1'b0;
        wishbone_ack_o  = 1'b0;
        wishbone_data_o = 32'h0;
        case (state)
            WB_SRAM_IDLE: begin
                if (request) begin
                    state_nxt = range_bad ? WB_SRAM_ACK : WB_SRAM_SETUP;
                end
            end
            WB_SRAM_SETUP: begin
                sram_ce_n_o = 1'b0;
                drive       = we_q;
                state_nxt   = WB_SRAM_ACCESS;
            end
            WB_SRAM_ACCESS: begin
                sram_ce_n_o = 1'b0;
                sram_oe_n_o = we_q;
                sram_we_n_o = !we_q;
                drive       = we_q;
                sample      = !we_q && (cnt_q == '0);
                if (cnt_q == '0) begin
                    state_nxt = WB_SRAM_ACK;
                end
            end
            WB_SRAM_ACK: begin
                // Rejected (out-of-range) requests ack without ever touching the SRAM.
                wishbone_ack_o  = 1'b1;
                sram_ce_n_o     = skip_q;
                drive           = we_q && !skip_q;
                wishbone_data_o = (we_q || skip_q) ? 32'h0 : rdata;
                state_nxt       = WB_SRAM_TURN;
            end
            WB_SRAM_TURN: begin
                state_nxt = WB_SRAM_IDLE;
            end
            default: begin
                state_nxt = WB_SRAM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (state == WB_SRAM_IDLE && request) begin
                addr_q  <= wishbone_addr_i[ADDR_W+1:2];
                wdata_q <= wishbone_data_i;
                we_q    <= wishbone_we_i;
                skip_q  <= range_bad;
            end
            if (state == WB_SRAM_SETUP) begin
                cnt_q <= CNT_W'(WAIT_EFF - 1);
            end else if (state == WB_SRAM_ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    sram_io_pad u_io_pad (
        .clk    (clk),
        .rst    (rst),
        .dout   (wdata_q),
        .drive  (drive),
        .sample (sample),
        .din    (rdata),
        .pad    (sram_data_io)
    );

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave with a small async SRAM model; a pullup makes an undriven bus read all-ones.
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    logic        we = 1'b0;
    logic [15:0] sel = '0;
    logic [31:0] data_o;
    logic        ack;
    logic [19:0] sram_addr;
    wire  [31:0] sram_data;
    logic        ce_n, oe_n, we_n;
    logic [3:0]  be_n;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:15];
    logic        r_ce [0:31];
    logic        r_oe [0:31];
    logic        r_we [0:31];
    logic        r_ack[0:31];
    logic        r_err[0:31];
    logic [31:0] r_do [0:31];
    logic [31:0] r_io [0:31];
    logic [19:0] r_adr[0:31];

    always #5 clk = ~clk;

    wb_sram_slave #(.DEV_IDX(0), .ADDR_W(20), .WAIT_CYCLES(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .wishbone_addr_i   (addr),
        .wishbone_data_i   (wdat),
        .wishbone_we_i     (we),
        .wishbone_select_i (sel),
        .wishbone_data_o   (data_o),
        .wishbone_ack_o    (ack),
        .sram_addr_o       (sram_addr),
        .sram_data_io      (sram_data),
        .sram_ce_n_o       (ce_n),
        .sram_oe_n_o       (oe_n),
        .sram_we_n_o       (we_n),
        .sram_be_n_o       (be_n),
        .err_o             (err)
    );

    pullup pu_data (sram_data);

    assign sram_data = (!ce_n && !oe_n) ? mem[sram_addr[3:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[3:0]] <= sram_data;
    end

    // Runs one request from cycle 0 (state IDLE); optionally swaps addr/data at cycle sw and drops select at cycle drop.
    task automatic capture(input logic [31:0] a1, input logic [31:0] d1, input logic w,
                           input logic [15:0] s, input int sw, input logic [31:0] a2,
                           input logic [31:0] d2, input int drop, input int n);
        @(posedge clk); #1;
        addr = a1; wdat = d1; we = w; sel = s;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == sw) begin addr = a2; wdat = d2; end
                if (c == drop) sel = 16'h0;
            end
            @(negedge clk);
            r_ce[c] = ce_n; r_oe[c] = oe_n; r_we[c] = we_n; r_ack[c] = ack;
            r_err[c] = err; r_do[c] = data_o; r_io[c] = sram_data; r_adr[c] = sram_addr;
        end
        sel = 16'h0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        addr = 32'h0000_0010; sel = 16'h0001; we = 1'b1;
        #12;
        vectors++;
        if ({ack, ce_n, oe_n, we_n, err} !== 5'b01110) begin
            miscompares++;
            $display("FAIL reset_ctrl got ack/ce/oe/we/err=%b exp 01110", {ack, ce_n, oe_n, we_n, err});
        end
        vectors++;
        if (data_o !== 32'h0 || sram_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_data got data_o=%h addr=%h exp 0/0", data_o, sram_addr);
        end
        vectors++;
        if (sram_data !== 32'hFFFF_FFFF || be_n !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_bus got io=%h be_n=%b exp FFFFFFFF(released)/0000", sram_data, be_n);
        end
        sel = 16'h0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_write;
        logic [31:0] eio;
        capture(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 16'h0001, -1, 32'h0, 32'h0, 5, 7);
        vectors++;
        if (r_adr[1] !== 20'h4) begin
            miscompares++;
            $display("FAIL wr_addr got %h exp 00004", r_adr[1]);
        end
        for (int c = 0; c < 7; c++) begin
            eio = (c >= 1 && c <= 4) ? 32'hDEAD_BEEF : 32'hFFFF_FFFF;
            vectors++;
            if (r_we[c] !== ((c == 2 || c == 3) ? 1'b0 : 1'b1) || r_oe[c] !== 1'b1 ||
                r_ce[c] !== ((c >= 1 && c <= 4) ? 1'b0 : 1'b1) || r_ack[c] !== (c == 4) ||
                r_io[c] !== eio) begin
                miscompares++;
                $display("FAIL wr_cyc%0d got ce/oe/we/ack=%b%b%b%b io=%h exp io=%h", c,
                         r_ce[c], r_oe[c], r_we[c], r_ack[c], r_io[c], eio);
            end
        end
    endtask

    task automatic test_read;
        logic [31:0] edo;
        capture(32'h0000_0010, 32'h0, 1'b0, 16'h0001, -1, 32'h0, 32'h0, 5, 7);
        for (int c = 0; c < 7; c++) begin
            edo = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
            vectors++;
            if (r_oe[c] !== ((c == 2 || c == 3) ? 1'b0 : 1'b1) || r_we[c] !== 1'b1 ||
                r_ack[c] !== (c == 4) || r_do[c] !== edo) begin
                miscompares++;
                $display("FAIL rd_cyc%0d got oe/we/ack=%b%b%b data_o=%h exp data_o=%h", c,
                         r_oe[c], r_we[c], r_ack[c], r_do[c], edo);
            end
        end
    endtask

    task automatic test_other_select;
        int bad;
        bad = 0;
        capture(32'h0000_0010, 32'h5555_0000, 1'b1, 16'h0002, -1, 32'h0, 32'h0, 99, 20);
        for (int c = 0; c < 20; c++) if (r_ce[c] !== 1'b1 || r_ack[c] !== 1'b0) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL other_sel got %0d cycles with ce_n low or ack, exp 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        capture(32'h0000_0010, 32'h1111_1111, 1'b1, 16'h0001, 5, 32'h0000_0014, 32'h2222_2222, 11, 14);
        vectors++;
        if (r_ce[5] !== 1'b1 || r_io[5] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL b2b_turn got ce_n=%b io=%h exp 1/FFFFFFFF(released)", r_ce[5], r_io[5]);
        end
        for (int c = 0; c < 14; c++) begin
            vectors++;
            if (r_ack[c] !== (c == 4 || c == 10)) begin
                miscompares++;
                $display("FAIL b2b_ack cyc%0d got %b exp %b", c, r_ack[c], (c == 4 || c == 10));
            end
        end
        vectors++;
        if (r_adr[8] !== 20'h5 || r_we[8] !== 1'b0 || r_io[8] !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL b2b_second got addr=%h we_n=%b io=%h exp 00005/0/22222222",
                     r_adr[8], r_we[8], r_io[8]);
        end
    endtask

    task automatic test_reset_abort;
        @(posedge clk); #1;
        addr = 32'h0000_0018; wdat = 32'h3333_3333; we = 1'b1; sel = 16'h0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (we_n !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre got we_n=%b exp 0", we_n);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({ce_n, oe_n, we_n, ack} !== 4'b1110 || sram_data !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL abort_now got ce/oe/we/ack=%b io=%h exp 1110/FFFFFFFF", {ce_n, oe_n, we_n, ack}, sram_data);
        end
        sel = 16'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (ack !== 1'b0 || ce_n !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_hold cyc%0d got ack=%b ce_n=%b exp 0/1", c, ack, ce_n);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        capture(32'h0000_0014, 32'h0, 1'b0, 16'h0001, -1, 32'h0, 32'h0, 5, 7);
        vectors++;
        if (r_ack[4] !== 1'b1 || r_do[4] !== 32'h2222_2222 || r_ack[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_next got ack4=%b data=%h ack3=%b exp 1/22222222/0", r_ack[4], r_do[4], r_ack[3]);
        end
        capture(32'h0000_0018, 32'h0, 1'b0, 16'h0001, -1, 32'h0, 32'h0, 5, 7);
        vectors++;
        if (r_do[4] !== 32'h1000_0006) begin
            miscompares++;
            $display("FAIL abort_nowrite got %h exp 10000006", r_do[4]);
        end
    endtask

`ifdef WB_SRAM_RANGE_CHK_EN
    task automatic test_range;
        capture(32'h8000_0000, 32'h0, 1'b0, 16'h0001, -1, 32'h0, 32'h0, 2, 6);
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (r_ack[c] !== (c == 1) || r_do[c] !== 32'h0 || r_ce[c] !== 1'b1 || r_err[c] !== (c >= 1)) begin
                miscompares++;
                $display("FAIL range_cyc%0d got ack/ce/err=%b%b%b data=%h exp ack=%b err=%b", c,
                         r_ack[c], r_ce[c], r_err[c], r_do[c], (c == 1), (c >= 1));
            end
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL range_clr got err=%b exp 0", err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask
`else
    task automatic test_range;
        capture(32'h0040_0010, 32'h0, 1'b0, 16'h0001, -1, 32'h0, 32'h0, 5, 7);
        vectors++;
        if (r_ack[4] !== 1'b1 || r_do[4] !== 32'h1111_1111 || r_adr[1] !== 20'h4 || r_err[6] !== 1'b0) begin
            miscompares++;
            $display("FAIL alias got ack=%b data=%h addr=%h err=%b exp 1/11111111/00004/0",
                     r_ack[4], r_do[4], r_adr[1], r_err[6]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        test_reset;
        test_write;
        test_read;
        test_other_select;
        test_back_to_back;
        test_reset_abort;
        test_range;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
